// File: rtl/lc3_pkg.sv
// Shared types, constants and the sign-extension helper for the LC-3 datapath.
package lc3_pkg;

    typedef enum logic [1:0] {
        PCMUX_INC   = 2'd0,
        PCMUX_BUS   = 2'd1,
        PCMUX_ADDER = 2'd2,
        PCMUX_HOLD  = 2'd3
    } pcmux_t;

    typedef enum logic [1:0] {
        ADDR2_ZERO  = 2'd0,
        ADDR2_OFF6  = 2'd1,
        ADDR2_OFF9  = 2'd2,
        ADDR2_OFF11 = 2'd3
    } addr2mux_t;

    typedef enum logic [1:0] {
        ALUK_ADD  = 2'd0,
        ALUK_AND  = 2'd1,
        ALUK_NOT  = 2'd2,
        ALUK_PASS = 2'd3
    } aluk_t;

    localparam logic [2:0] NZP_RESET = 3'b010;
    localparam int SEXT_MAX = 64;

    // Returns a 64-bit result; callers slice [WIDTH-1:0], so WIDTH is limited to 64.
    function automatic logic [SEXT_MAX-1:0] sext(input logic [15:0] field,
                                                 input logic [3:0]  sign_bit);
        logic [SEXT_MAX-1:0] result;
        result = '0;
        for (int i = 0; i < SEXT_MAX; i++) begin
            result[i] = (i <= int'(sign_bit)) ? field[i[3:0]] : field[sign_bit];
        end
        return result;
    endfunction

endpackage

// File: rtl/lc3_regfile.sv
// Eight-entry register file: synchronous write, two combinational read ports.
module lc3_regfile #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld,
    input  logic [2:0]       dr,
    input  logic [WIDTH-1:0] din,
    input  logic [2:0]       sr1,
    input  logic [2:0]       sr2,
    output logic [WIDTH-1:0] sr1_out,
    output logic [WIDTH-1:0] sr2_out
);

    logic [WIDTH-1:0] regs [8];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (ld) begin
            regs[dr] <= din;
        end
    end

    // Reads see the pre-write value during a write cycle.
    assign sr1_out = regs[sr1];
    assign sr2_out = regs[sr2];

endmodule

// File: rtl/lc3_datapath.sv
// LC-3 datapath: architectural registers, ALU, address adder and a single gated bus
// with sticky detection of multiple simultaneous drivers.
module lc3_datapath
    import lc3_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             LD_MAR,
    input  logic             LD_MDR,
    input  logic             LD_IR,
    input  logic             LD_BEN,
    input  logic             LD_CC,
    input  logic             LD_REG,
    input  logic             LD_PC,
    input  logic             LD_LED,
    input  logic             GatePC,
    input  logic             GateMDR,
    input  logic             GateALU,
    input  logic             GateMARMUX,
    input  logic [1:0]       PCMUX,
    input  logic             DRMUX,
    input  logic             SR1MUX,
    input  logic             SR2MUX,
    input  logic             ADDR1MUX,
    input  logic [1:0]       ADDR2MUX,
    input  logic [1:0]       ALUK,
    input  logic             MIO_EN,
    input  logic [WIDTH-1:0] MDR_In,
    output logic [WIDTH-1:0] MAR,
    output logic [WIDTH-1:0] MDR,
    output logic [WIDTH-1:0] IR,
    output logic [WIDTH-1:0] PC,
    output logic             BEN,
    output logic [2:0]       NZP,
    output logic [11:0]      LED,
    output logic             BUS_ERR
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] bus;
    logic [WIDTH-1:0] sr1_out;
    logic [WIDTH-1:0] sr2_out;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] addr1;
    logic [WIDTH-1:0] addr2;
    logic [WIDTH-1:0] adder_out;
    logic [WIDTH-1:0] pc_next;
    logic [2:0]       sr1_idx;
    logic [2:0]       dr_idx;
    logic [3:0]       gates;
    logic             multi_drive;
    logic [2:0]       cc_next;
    logic             ben_next;

    logic [SEXT_MAX-1:0] sext5_full;
    logic [SEXT_MAX-1:0] sext6_full;
    logic [SEXT_MAX-1:0] sext9_full;
    logic [SEXT_MAX-1:0] sext11_full;

    assign sext5_full  = sext(IR[15:0], 4'd4);
    assign sext6_full  = sext(IR[15:0], 4'd5);
    assign sext9_full  = sext(IR[15:0], 4'd8);
    assign sext11_full = sext(IR[15:0], 4'd10);

    assign sr1_idx = SR1MUX ? IR[8:6] : IR[11:9];
    assign dr_idx  = DRMUX ? 3'd7 : IR[11:9];

    lc3_regfile #(.WIDTH(WIDTH)) u_regfile (
        .clk     (Clk),
        .reset   (Reset),
        .ld      (LD_REG),
        .dr      (dr_idx),
        .din     (bus),
        .sr1     (sr1_idx),
        .sr2     (IR[2:0]),
        .sr1_out (sr1_out),
        .sr2_out (sr2_out)
    );

    assign alu_b = SR2MUX ? sext5_full[WIDTH-1:0] : sr2_out;

    always_comb begin
        alu_out = '0;
        case (aluk_t'(ALUK))
            ALUK_ADD:  alu_out = sr1_out + alu_b;
            ALUK_AND:  alu_out = sr1_out & alu_b;
            ALUK_NOT:  alu_out = ~sr1_out;
            ALUK_PASS: alu_out = sr1_out;
            default:   alu_out = '0;
        endcase
    end

    assign addr1 = ADDR1MUX ? sr1_out : PC;

    always_comb begin
        addr2 = '0;
        case (addr2mux_t'(ADDR2MUX))
            ADDR2_ZERO:  addr2 = '0;
            ADDR2_OFF6:  addr2 = sext6_full[WIDTH-1:0];
            ADDR2_OFF9:  addr2 = sext9_full[WIDTH-1:0];
            ADDR2_OFF11: addr2 = sext11_full[WIDTH-1:0];
            default:     addr2 = '0;
        endcase
    end

    assign adder_out = addr1 + addr2;

    always_comb begin
        pc_next = PC;
        case (pcmux_t'(PCMUX))
            PCMUX_INC:   pc_next = PC + ONE;
            PCMUX_BUS:   pc_next = bus;
            PCMUX_ADDER: pc_next = adder_out;
            PCMUX_HOLD:  pc_next = PC;
            default:     pc_next = PC;
        endcase
    end

    // Only a one-hot gate pattern drives the bus; anything else floats to zero.
    assign gates       = {GatePC, GateMDR, GateALU, GateMARMUX};
    assign multi_drive = |(gates & (gates - 4'd1));

    always_comb begin
        bus = '0;
        case (gates)
            4'b1000: bus = PC;
            4'b0100: bus = MDR;
            4'b0010: bus = alu_out;
            4'b0001: bus = adder_out;
            default: bus = '0;
        endcase
    end

    assign cc_next[2] = bus[WIDTH-1];
    assign cc_next[1] = (bus == '0);
    assign cc_next[0] = !cc_next[2] && !cc_next[1];

    // Built from the registered IR and NZP, so same-cycle LD_IR/LD_CC are not seen.
    assign ben_next = (IR[11] & NZP[2]) | (IR[10] & NZP[1]) | (IR[9] & NZP[0]);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            MAR     <= '0;
            MDR     <= '0;
            IR      <= '0;
            PC      <= RESET_PC;
            NZP     <= NZP_RESET;
            BEN     <= 1'b0;
            LED     <= '0;
            BUS_ERR <= 1'b0;
        end else begin
            if (LD_MAR) MAR <= bus;
            if (LD_MDR) MDR <= MIO_EN ? MDR_In : bus;
            if (LD_IR)  IR  <= bus;
            if (LD_PC)  PC  <= pc_next;
            if (LD_CC)  NZP <= cc_next;
            if (LD_BEN) BEN <= ben_next;
            if (LD_LED) LED <= IR[11:0];
            if (multi_drive) BUS_ERR <= 1'b1;
        end
    end

endmodule
